branch_condition_unit: RTL and testbench
========================================

BRANCH_CONDITION_UNIT -- requirements
Module: branch_condition_unit

Interface
REQ-001 Parameter: WIDTH, 16, PC/address width.
REQ-002 Parameter: DISP_W, 8, branch displacement width (two's complement).
REQ-003 Port: clock  in  1  single clock; all state changes on posedge clock.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: flags_in  in  5  processor status register output, bit order {C,Z,L,F,N} = [4:0].
REQ-006 Port: flags_pending  in  1  a flag-writing instruction is in flight; flags_in not yet final.
REQ-007 Port: req_valid / req_ready  in / out  1 / 1  branch request handshake.
REQ-008 Port: is_jump  in  1  1 = Jcond (register target), 0 = Bcond (PC-relative).
REQ-009 Port: cond  in  4  condition code.
REQ-010 Port: pc_in  in  WIDTH  address of the branch instruction.
REQ-011 Port: disp  in  DISP_W  signed displacement.
REQ-012 Port: rtarget  in  WIDTH  register target for Jcond.
REQ-013 Port: flush  in  1  synchronous abort of any in-flight request.
REQ-014 Port: redirect_valid / redirect_ready  out / in  1 / 1  result handshake.
REQ-015 Port: redirect_pc  out  WIDTH  next PC.
REQ-016 Port: taken  out  1  condition evaluated true.
REQ-017 Port: taken_count  out  16  saturating count of completed taken branches.

Function
REQ-018 States: IDLE, WAIT_FLAGS, RESOLVE, REDIRECT; req_ready SHALL be 1 only in IDLE.
REQ-019 Accept (req_valid & req_ready): latch is_jump, cond, pc_in, disp, rtarget; next state WAIT_FLAGS if flags_pending else RESOLVE.
REQ-020 WAIT_FLAGS: hold while flags_pending = 1; go to RESOLVE in the cycle after flags_pending = 0 is seen.
REQ-021 RESOLVE (exactly one cycle): sample flags_in, evaluate, register taken and redirect_pc, go to REDIRECT.
REQ-022 Conditions: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F; A LO !L&!Z; B HS L|Z; C LT !N&!Z; D GE N|Z; E UC 1; F never 0.
REQ-023 Target: taken & is_jump -> rtarget; taken & !is_jump -> pc + sign_extend(disp), modulo 2^WIDTH; not taken -> pc + 1, modulo 2^WIDTH.
REQ-024 REDIRECT: redirect_valid = 1, redirect_pc and taken held stable until redirect_ready = 1; on that cycle return to IDLE.
REQ-025 taken_count SHALL increment on a completed redirect handshake with taken = 1, saturating at 0xFFFF.
REQ-026 Latency: flags_pending = 0 and redirect_ready = 1 -> accept cycle N, redirect_valid high cycle N+2, req_ready high cycle N+3.
REQ-027 flush = 1 in any state SHALL force IDLE next cycle, deassert redirect_valid, leave taken_count unchanged; flush has priority over a same-cycle redirect handshake and over acceptance.
REQ-028 redirect_valid SHALL be 0 outside REDIRECT; taken and redirect_pc SHALL retain their last values outside REDIRECT.

Reset
REQ-029 reset low SHALL immediately force IDLE, redirect_valid = 0, taken = 0, redirect_pc = 0, taken_count = 0, all latched request fields = 0.
REQ-030 No request SHALL be accepted while reset is low; reset mid-operation discards the request without a redirect.

Structure
REQ-031 Condition-code constants, flag bit indices and state encoding SHALL live in the shared CPU package.
REQ-032 Condition evaluation SHALL be a separate combinational sub-module cond_eval (flags, cond -> result).

Verification
REQ-033 flags_in = 5'b01000 (Z), cond = 0 EQ, is_jump = 0, pc_in = 0x0010, disp = 0xFC -> redirect_pc = 0x000C, taken = 1 at accept+2.
REQ-034 Same request, flags_in = 0 -> taken = 0, redirect_pc = 0x0011; taken_count unchanged.
REQ-035 flags_pending high 3 cycles after accept, flags_in changes from 0 to Z during the wait, cond = EQ -> taken = 1, redirect_valid at accept+5.
REQ-036 Jcond UC, rtarget = 0xBEEF, redirect_ready low 4 cycles -> redirect_valid/redirect_pc = 0xBEEF stable all 4 cycles; taken_count +1 only on handshake.
REQ-037 Bcond pc_in = 0xFFFF, disp = 0x01, UC -> redirect_pc = 0x0000; cond = F -> never taken, redirect_pc = 0x0000.
REQ-038 flush in RESOLVE and reset low in REDIRECT -> no redirect handshake, IDLE next cycle, req_ready = 1, taken_count preserved (flush) or 0 (reset).

Source files
------------

// File: rtl/branch_condition_unit_pkg.sv
// Shared CPU definitions: status flag bit positions, condition codes and
// branch-unit state encoding.
package branch_condition_unit_pkg;

  localparam int unsigned NUM_FLAGS = 5;
  localparam int unsigned COND_W    = 4;
  localparam int unsigned CNT_W     = 16;

  // Status register layout {C,Z,L,F,N} = [4:0]
  localparam int unsigned FLAG_C = 4;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_L = 2;
  localparam int unsigned FLAG_F = 1;
  localparam int unsigned FLAG_N = 0;

  typedef enum logic [COND_W-1:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_HI = 4'h4,
    COND_LS = 4'h5,
    COND_GT = 4'h6,
    COND_LE = 4'h7,
    COND_FS = 4'h8,
    COND_FC = 4'h9,
    COND_LO = 4'hA,
    COND_HS = 4'hB,
    COND_LT = 4'hC,
    COND_GE = 4'hD,
    COND_UC = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FLAGS = 2'd1,
    ST_RESOLVE    = 2'd2,
    ST_REDIRECT   = 2'd3
  } state_e;

endpackage

// File: rtl/branch_condition_unit_if.sv
// Branch request / redirect result bundle between the fetch side and the
// branch condition unit.
interface branch_condition_unit_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DISP_W = 8
);
  import branch_condition_unit_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                is_jump;
  logic [COND_W-1:0]   cond;
  logic [WIDTH-1:0]    pc_in;
  logic [DISP_W-1:0]   disp;
  logic [WIDTH-1:0]    rtarget;
  logic                redirect_valid;
  logic                redirect_ready;
  logic [WIDTH-1:0]    redirect_pc;
  logic                taken;

  modport master (
    output req_valid, is_jump, cond, pc_in, disp, rtarget, redirect_ready,
    input  req_ready, redirect_valid, redirect_pc, taken
  );

  modport slave (
    input  req_valid, is_jump, cond, pc_in, disp, rtarget, redirect_ready,
    output req_ready, redirect_valid, redirect_pc, taken
  );

endinterface

// File: rtl/branch_condition_unit_cond_eval.sv
// Combinational evaluation of a 4-bit condition code against the status flags.
module cond_eval
  import branch_condition_unit_pkg::*;
(
  input  logic [NUM_FLAGS-1:0] flags_i,
  input  logic [COND_W-1:0]    cond_i,
  output logic                 result_c
);

  logic c_f, z_f, l_f, f_f, n_f;

  assign c_f = flags_i[FLAG_C];
  assign z_f = flags_i[FLAG_Z];
  assign l_f = flags_i[FLAG_L];
  assign f_f = flags_i[FLAG_F];
  assign n_f = flags_i[FLAG_N];

  always_comb begin
    result_c = 1'b0;
    case (cond_i)
      COND_EQ: result_c = z_f;
      COND_NE: result_c = ~z_f;
      COND_CS: result_c = c_f;
      COND_CC: result_c = ~c_f;
      COND_HI: result_c = l_f;
      COND_LS: result_c = ~l_f;
      COND_GT: result_c = n_f;
      COND_LE: result_c = ~n_f;
      COND_FS: result_c = f_f;
      COND_FC: result_c = ~f_f;
      COND_LO: result_c = ~l_f & ~z_f;
      COND_HS: result_c = l_f | z_f;
      COND_LT: result_c = ~n_f & ~z_f;
      COND_GE: result_c = n_f | z_f;
      COND_UC: result_c = 1'b1;
      default: result_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_condition_unit.sv
// Resolves Bcond/Jcond requests: waits for final flags, evaluates the
// condition and presents the next PC on a ready/valid redirect port.
module branch_condition_unit
  import branch_condition_unit_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DISP_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_FLAGS-1:0]  flags_in,
  input  logic                  flags_pending,
  input  logic                  flush,
  branch_condition_unit_if.slave bus,
  output logic [CNT_W-1:0]      taken_count
);

  state_e              state_q;
  logic                req_ready_q;
  logic                redirect_valid_q;
  logic                taken_q;
  logic [WIDTH-1:0]    redirect_pc_q;
  logic [CNT_W-1:0]    count_q;

  logic                is_jump_q;
  logic [COND_W-1:0]   cond_q;
  logic [WIDTH-1:0]    pc_q;
  logic [DISP_W-1:0]   disp_q;
  logic [WIDTH-1:0]    rtarget_q;

  logic                cond_hit_c;
  logic                accept_c;
  logic [WIDTH-1:0]    disp_ext_c;
  logic [WIDTH-1:0]    target_c;

  cond_eval u_cond_eval (
    .flags_i  (flags_in),
    .cond_i   (cond_q),
    .result_c (cond_hit_c)
  );

  assign accept_c   = bus.req_valid & req_ready_q;
  assign disp_ext_c = {{(WIDTH-DISP_W){disp_q[DISP_W-1]}}, disp_q};

  // Next PC: register target, PC-relative target, or fall-through; wraps mod 2^WIDTH
  always_comb begin
    target_c = pc_q + WIDTH'(1);
    if (cond_hit_c) begin
      target_c = is_jump_q ? rtarget_q : (pc_q + disp_ext_c);
    end
  end

  // Control FSM with registered handshake outputs; flush overrides every state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      req_ready_q      <= 1'b1;
      redirect_valid_q <= 1'b0;
      taken_q          <= 1'b0;
      redirect_pc_q    <= '0;
      count_q          <= '0;
      is_jump_q        <= 1'b0;
      cond_q           <= '0;
      pc_q             <= '0;
      disp_q           <= '0;
      rtarget_q        <= '0;
    end else if (flush) begin
      state_q          <= ST_IDLE;
      req_ready_q      <= 1'b1;
      redirect_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            is_jump_q   <= bus.is_jump;
            cond_q      <= bus.cond;
            pc_q        <= bus.pc_in;
            disp_q      <= bus.disp;
            rtarget_q   <= bus.rtarget;
            req_ready_q <= 1'b0;
            state_q     <= flags_pending ? ST_WAIT_FLAGS : ST_RESOLVE;
          end
        end
        ST_WAIT_FLAGS: begin
          if (!flags_pending) begin
            state_q <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          taken_q          <= cond_hit_c;
          redirect_pc_q    <= target_c;
          redirect_valid_q <= 1'b1;
          state_q          <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (bus.redirect_ready) begin
            if (taken_q && (count_q != '1)) begin
              count_q <= count_q + CNT_W'(1);
            end
            redirect_valid_q <= 1'b0;
            req_ready_q      <= 1'b1;
            state_q          <= ST_IDLE;
          end
        end
        default: begin
          redirect_valid_q <= 1'b0;
          req_ready_q      <= 1'b1;
          state_q          <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.taken          = taken_q;
  assign taken_count        = count_q;

endmodule

// File: tb/tb_branch_condition_unit.sv
// Directed self-checking bench for branch_condition_unit: a vector table for
// condition/target evaluation plus hand-written multi-cycle sequences.
module tb_branch_condition_unit;

  logic        clock;
  logic        reset;
  logic [4:0]  flags_in;
  logic        flags_pending;
  logic        flush;
  logic [15:0] taken_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_count;

  branch_condition_unit_if #(.WIDTH(16), .DISP_W(8)) bus ();

  branch_condition_unit #(.WIDTH(16), .DISP_W(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .flags_in      (flags_in),
    .flags_pending (flags_pending),
    .flush         (flush),
    .bus           (bus),
    .taken_count   (taken_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  flags;
    logic        is_jump;
    logic [3:0]  cond;
    logic [15:0] pc;
    logic [7:0]  disp;
    logic [15:0] rtarget;
    logic        exp_taken;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [4:0] f, input logic j, input logic [3:0] c,
                     input logic [15:0] pc, input logic [7:0] d,
                     input logic [15:0] rt, input logic et, input logic [15:0] ep);
    vec_t v;
    v.flags = f; v.is_jump = j; v.cond = c; v.pc = pc; v.disp = d;
    v.rtarget = rt; v.exp_taken = et; v.exp_pc = ep;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic j, input logic [3:0] c, input logic [15:0] pc,
                           input logic [7:0] d, input logic [15:0] rt);
    bus.req_valid = 1'b1;
    bus.is_jump   = j;
    bus.cond      = c;
    bus.pc_in     = pc;
    bus.disp      = d;
    bus.rtarget   = rt;
  endtask

  // One request with flags already final and redirect_ready high: N, N+1, N+2, N+3
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    flags_in          = v.flags;
    flags_pending     = 1'b0;
    bus.redirect_ready = 1'b1;
    drive_req(v.is_jump, v.cond, v.pc, v.disp, v.rtarget);
    chk({tag, "_acc_ready"}, 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    chk({tag, "_resolve_valid"}, 32'(bus.redirect_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(bus.redirect_valid), 32'd1);
    chk({tag, "_taken"}, 32'(bus.taken), 32'(v.exp_taken));
    chk({tag, "_pc"}, 32'(bus.redirect_pc), 32'(v.exp_pc));
    if (v.exp_taken) exp_count = exp_count + 16'd1;
    step();
    chk({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_count"}, 32'(taken_count), 32'(exp_count));
  endtask

  initial begin
    reset = 1'b0;
    flags_in = '0;
    flags_pending = 1'b0;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.is_jump = 1'b0;
    bus.cond = '0;
    bus.pc_in = '0;
    bus.disp = '0;
    bus.rtarget = '0;
    bus.redirect_ready = 1'b1;
    exp_count = '0;

    repeat (2) step();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_valid", 32'(bus.redirect_valid), 32'd0);
    chk("rst_taken", 32'(bus.taken), 32'd0);
    chk("rst_pc", 32'(bus.redirect_pc), 32'd0);
    chk("rst_count", 32'(taken_count), 32'd0);
    reset = 1'b1;
    step();

    // flags bits: C=10 Z=08 L=04 F=02 N=01; pc 0x10 + disp 0xFC = 0x0C
    add(5'h08, 0, 4'h0, 16'h0010, 8'hFC, 16'h0000, 1, 16'h000C);
    add(5'h00, 0, 4'h0, 16'h0010, 8'hFC, 16'h0000, 0, 16'h0011);
    add(5'h08, 0, 4'h1, 16'h0010, 8'hFC, 16'h0000, 0, 16'h0011);
    add(5'h10, 0, 4'h2, 16'h0010, 8'hFC, 16'h0000, 1, 16'h000C);
    add(5'h10, 0, 4'h3, 16'h0010, 8'hFC, 16'h0000, 0, 16'h0011);
    add(5'h04, 0, 4'h4, 16'h0010, 8'hFC, 16'h0000, 1, 16'h000C);
    add(5'h00, 0, 4'h5, 16'h0010, 8'hFC, 16'h0000, 1, 16'h000C);
    add(5'h01, 0, 4'h6, 16'h0010, 8'hFC, 16'h0000, 1, 16'h000C);
    add(5'h01, 0, 4'h7, 16'h0010, 8'hFC, 16'h0000, 0, 16'h0011);
    add(5'h02, 0, 4'h8, 16'h0010, 8'hFC, 16'h0000, 1, 16'h000C);
    add(5'h00, 0, 4'h9, 16'h0010, 8'hFC, 16'h0000, 1, 16'h000C);
    add(5'h08, 0, 4'hA, 16'h0010, 8'hFC, 16'h0000, 0, 16'h0011);
    add(5'h00, 0, 4'hA, 16'h0010, 8'hFC, 16'h0000, 1, 16'h000C);
    add(5'h08, 0, 4'hB, 16'h0010, 8'hFC, 16'h0000, 1, 16'h000C);
    add(5'h00, 0, 4'hB, 16'h0010, 8'hFC, 16'h0000, 0, 16'h0011);
    add(5'h00, 0, 4'hC, 16'h0010, 8'hFC, 16'h0000, 1, 16'h000C);
    add(5'h01, 0, 4'hC, 16'h0010, 8'hFC, 16'h0000, 0, 16'h0011);
    add(5'h08, 0, 4'hD, 16'h0010, 8'hFC, 16'h0000, 1, 16'h000C);
    add(5'h00, 0, 4'hD, 16'h0010, 8'hFC, 16'h0000, 0, 16'h0011);
    add(5'h1F, 1, 4'hE, 16'h0010, 8'hFC, 16'h1234, 1, 16'h1234);
    add(5'h1F, 0, 4'hF, 16'h0010, 8'hFC, 16'h0000, 0, 16'h0011);
    add(5'h00, 1, 4'h0, 16'h0010, 8'hFC, 16'h1234, 0, 16'h0011);
    add(5'h00, 0, 4'hE, 16'hFFFF, 8'h01, 16'h0000, 1, 16'h0000);
    add(5'h00, 0, 4'hF, 16'hFFFF, 8'h01, 16'h0000, 0, 16'h0000);
    add(5'h00, 0, 4'hE, 16'h0100, 8'h7F, 16'h0000, 1, 16'h017F);
    add(5'h00, 0, 4'hE, 16'h0000, 8'h80, 16'h0000, 1, 16'hFF80);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Flags pending for the accept cycle and two more; flags change during the wait
    flags_in = 5'h00;
    flags_pending = 1'b1;
    bus.redirect_ready = 1'b1;
    drive_req(1'b0, 4'h0, 16'h0010, 8'hFC, 16'h0000);
    step();                                   // N+1
    bus.req_valid = 1'b0;
    chk("wait_valid1", 32'(bus.redirect_valid), 32'd0);
    chk("wait_ready1", 32'(bus.req_ready), 32'd0);
    step();                                   // N+2
    flags_in = 5'h08;
    chk("wait_valid2", 32'(bus.redirect_valid), 32'd0);
    step();                                   // N+3
    flags_pending = 1'b0;
    chk("wait_valid3", 32'(bus.redirect_valid), 32'd0);
    step();                                   // N+4
    chk("wait_valid4", 32'(bus.redirect_valid), 32'd0);
    step();                                   // N+5
    chk("wait_valid5", 32'(bus.redirect_valid), 32'd1);
    chk("wait_taken", 32'(bus.taken), 32'd1);
    chk("wait_pc", 32'(bus.redirect_pc), 32'h000C);
    exp_count = exp_count + 16'd1;
    step();
    chk("wait_count", 32'(taken_count), 32'(exp_count));
    chk("wait_ready_back", 32'(bus.req_ready), 32'd1);

    // Redirect back-pressure: Jcond UC held for four cycles
    bus.redirect_ready = 1'b0;
    drive_req(1'b1, 4'hE, 16'h0040, 8'h00, 16'hBEEF);
    step();
    bus.req_valid = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_valid%0d", k), 32'(bus.redirect_valid), 32'd1);
      chk($sformatf("bp_pc%0d", k), 32'(bus.redirect_pc), 32'hBEEF);
      chk($sformatf("bp_count%0d", k), 32'(taken_count), 32'(exp_count));
      step();
    end
    bus.redirect_ready = 1'b1;
    chk("bp_valid_last", 32'(bus.redirect_valid), 32'd1);
    exp_count = exp_count + 16'd1;
    step();
    chk("bp_count_after", 32'(taken_count), 32'(exp_count));
    chk("bp_ready_back", 32'(bus.req_ready), 32'd1);

    // Flush during RESOLVE: outputs keep previous values, no redirect
    drive_req(1'b1, 4'hE, 16'h0040, 8'h00, 16'h4444);
    step();
    bus.req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flr_ready", 32'(bus.req_ready), 32'd1);
    chk("flr_valid", 32'(bus.redirect_valid), 32'd0);
    chk("flr_taken", 32'(bus.taken), 32'd1);
    chk("flr_pc", 32'(bus.redirect_pc), 32'hBEEF);
    chk("flr_count", 32'(taken_count), 32'(exp_count));
    step();
    chk("flr_valid_later", 32'(bus.redirect_valid), 32'd0);

    // Flush beats acceptance in IDLE
    drive_req(1'b0, 4'hE, 16'h0030, 8'h04, 16'h0000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    chk("fla_ready", 32'(bus.req_ready), 32'd1);
    step();
    chk("fla_valid", 32'(bus.redirect_valid), 32'd0);
    step();
    chk("fla_valid2", 32'(bus.redirect_valid), 32'd0);

    // Flush beats a same-cycle redirect handshake
    drive_req(1'b0, 4'hE, 16'h0020, 8'h02, 16'h0000);
    step();
    bus.req_valid = 1'b0;
    step();
    chk("flh_valid", 32'(bus.redirect_valid), 32'd1);
    chk("flh_pc", 32'(bus.redirect_pc), 32'h0022);
    flush = 1'b1;
    bus.redirect_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("flh_valid_after", 32'(bus.redirect_valid), 32'd0);
    chk("flh_count", 32'(taken_count), 32'(exp_count));
    chk("flh_ready", 32'(bus.req_ready), 32'd1);
    chk("flh_pc_kept", 32'(bus.redirect_pc), 32'h0022);

    // Asynchronous reset while in REDIRECT
    bus.redirect_ready = 1'b0;
    drive_req(1'b1, 4'hE, 16'h0040, 8'h00, 16'h5A5A);
    step();
    bus.req_valid = 1'b0;
    step();
    chk("rr_valid_pre", 32'(bus.redirect_valid), 32'd1);
    #1 reset = 1'b0;
    bus.req_valid = 1'b1;
    #1;
    chk("rr_valid", 32'(bus.redirect_valid), 32'd0);
    chk("rr_taken", 32'(bus.taken), 32'd0);
    chk("rr_pc", 32'(bus.redirect_pc), 32'd0);
    chk("rr_count", 32'(taken_count), 32'd0);
    chk("rr_ready", 32'(bus.req_ready), 32'd1);
    step();
    chk("rr_valid_held", 32'(bus.redirect_valid), 32'd0);
    bus.req_valid = 1'b0;
    bus.redirect_ready = 1'b1;
    reset = 1'b1;
    step();
    chk("rr_ready_after", 32'(bus.req_ready), 32'd1);
    chk("rr_valid_after", 32'(bus.redirect_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
